// File: rtl/sobel_pkg.sv
// Shared widths, latency constant and FSM state type for the Sobel edge pipeline.
package sobel_pkg;

  localparam int unsigned PIX_W    = 8;
  localparam int unsigned GRAD_W   = 11;
  localparam int unsigned ABS_W    = 10;
  localparam int unsigned SUM_W    = 11;
  localparam int unsigned PIPE_LAT = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // Magnitude of a signed gradient; |-1020| still fits in ABS_W bits.
  function automatic logic [ABS_W-1:0] abs_grad(input logic signed [GRAD_W-1:0] g);
    logic [GRAD_W-1:0] neg;
    neg = GRAD_W'(-g);
    return g[GRAD_W-1] ? neg[ABS_W-1:0] : g[ABS_W-1:0];
  endfunction

endpackage

// File: rtl/sobel_edge_3x3_grad.sv
// Stage S1 gradient kernel: registered horizontal and vertical Sobel sums.
module sobel_grad
  import sobel_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_i,
  input  logic [PIX_W-1:0]         p1_i,
  input  logic [PIX_W-1:0]         p2_i,
  input  logic [PIX_W-1:0]         p3_i,
  input  logic [PIX_W-1:0]         p4_i,
  input  logic [PIX_W-1:0]         p6_i,
  input  logic [PIX_W-1:0]         p7_i,
  input  logic [PIX_W-1:0]         p8_i,
  input  logic [PIX_W-1:0]         p9_i,
  output logic signed [GRAD_W-1:0] gx_o,
  output logic signed [GRAD_W-1:0] gy_o
);

  logic [GRAD_W-1:0]        gx_pos_c, gx_neg_c, gy_pos_c, gy_neg_c;
  logic signed [GRAD_W-1:0] gx_d, gx_q, gy_d, gy_q;

  // Zero-extend every pixel before the weighted sums so the difference is true signed.
  always_comb begin
    gx_pos_c = GRAD_W'(p3_i) + (GRAD_W'(p6_i) << 1) + GRAD_W'(p9_i);
    gx_neg_c = GRAD_W'(p1_i) + (GRAD_W'(p4_i) << 1) + GRAD_W'(p7_i);
    gy_pos_c = GRAD_W'(p7_i) + (GRAD_W'(p8_i) << 1) + GRAD_W'(p9_i);
    gy_neg_c = GRAD_W'(p1_i) + (GRAD_W'(p2_i) << 1) + GRAD_W'(p3_i);
    gx_d     = signed'(gx_pos_c - gx_neg_c);
    gy_d     = signed'(gy_pos_c - gy_neg_c);
  end

  // Capture gradients only for accepted windows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gx_q <= '0;
      gy_q <= '0;
    end else if (en_i) begin
      gx_q <= gx_d;
      gy_q <= gy_d;
    end
  end

  assign gx_o = gx_q;
  assign gy_o = gy_q;

endmodule

// File: rtl/sobel_edge_3x3.sv
// Three-stage Sobel edge detector with frame accounting (IDLE/RUN/FLUSH).
module sobel_edge_3x3
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_W = 256,
  parameter int unsigned IMG_H = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             win_valid_i,
  input  logic [PIX_W-1:0] p1_i,
  input  logic [PIX_W-1:0] p2_i,
  input  logic [PIX_W-1:0] p3_i,
  input  logic [PIX_W-1:0] p4_i,
  input  logic [PIX_W-1:0] p5_i,
  input  logic [PIX_W-1:0] p6_i,
  input  logic [PIX_W-1:0] p7_i,
  input  logic [PIX_W-1:0] p8_i,
  input  logic [PIX_W-1:0] p9_i,
  input  logic             bin_mode_i,
  input  logic [PIX_W-1:0] thresh_i,
  output logic [PIX_W-1:0] edge_out_o,
  output logic             edge_valid_o,
  output logic             frame_done_o,
  output logic             overrun_o,
  output logic             busy_o
);

  localparam int unsigned FRAME_PIX = IMG_W * IMG_H;
  localparam int unsigned CNT_W     = 15;
  localparam int unsigned COL_W     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W     = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         in_cnt_q, in_cnt_d;
  logic                     accept_c;
  logic                     v1_q, v2_q;
  logic signed [GRAD_W-1:0] gx_s1, gy_s1;
  logic [ABS_W-1:0]         ax_q, ay_q;
  logic [SUM_W-1:0]         sum_c;
  logic [PIX_W-1:0]         mag_c;
  logic [PIX_W-1:0]         edge_q, edge_d;
  logic                     ev_q;
  logic                     fd_q, fd_d;
  logic                     ovr_q, ovr_d;
  logic                     busy_q, busy_d;
  logic [COL_W-1:0]         col_q, col_d;
  logic [ROW_W-1:0]         row_q, row_d;

  // p5 has zero weight in both kernels.
  logic                     unused_p5;
  assign unused_p5 = ^p5_i;

  sobel_grad u_grad (
    .clk  (clk),
    .rst  (rst),
    .en_i (accept_c),
    .p1_i (p1_i),
    .p2_i (p2_i),
    .p3_i (p3_i),
    .p4_i (p4_i),
    .p6_i (p6_i),
    .p7_i (p7_i),
    .p8_i (p8_i),
    .p9_i (p9_i),
    .gx_o (gx_s1),
    .gy_o (gy_s1)
  );

  // Frame FSM: accept and count windows, refuse them while draining.
  always_comb begin
    state_d  = state_q;
    in_cnt_d = in_cnt_q;
    accept_c = 1'b0;
    case (state_q)
      IDLE, RUN: begin
        if (win_valid_i) begin
          accept_c = 1'b1;
          state_d  = RUN;
          if (in_cnt_q == CNT_W'(FRAME_PIX - 1)) begin
            in_cnt_d = '0;
            state_d  = FLUSH;
          end else begin
            in_cnt_d = in_cnt_q + CNT_W'(1);
          end
        end
      end
      FLUSH: begin
        if (fd_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // S3 magnitude, saturation, threshold; output position tracking and flags.
  always_comb begin
    sum_c  = SUM_W'(ax_q) + SUM_W'(ay_q);
    mag_c  = (sum_c > SUM_W'(255)) ? 8'hFF : sum_c[PIX_W-1:0];
    edge_d = bin_mode_i ? ((mag_c >= thresh_i) ? 8'hFF : 8'h00) : mag_c;

    col_d = col_q;
    row_d = row_q;
    if (ev_q) begin
      if (col_q == COL_W'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (row_q == ROW_W'(IMG_H - 1)) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end

    // Position of the output about to be presented decides the end-of-frame pulse.
    fd_d   = v2_q && (col_d == COL_W'(IMG_W - 1)) && (row_d == ROW_W'(IMG_H - 1));
    ovr_d  = ovr_q | ((state_q == FLUSH) && win_valid_i);
    busy_d = (state_d != IDLE);
  end

  // State, counters and pipeline registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      in_cnt_q <= '0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      ax_q     <= '0;
      ay_q     <= '0;
      edge_q   <= '0;
      ev_q     <= 1'b0;
      fd_q     <= 1'b0;
      ovr_q    <= 1'b0;
      busy_q   <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
    end else begin
      state_q  <= state_d;
      in_cnt_q <= in_cnt_d;
      v1_q     <= accept_c;
      v2_q     <= v1_q;
      if (v1_q) begin
        ax_q <= abs_grad(gx_s1);
        ay_q <= abs_grad(gy_s1);
      end
      if (v2_q) edge_q <= edge_d;
      ev_q     <= v2_q;
      fd_q     <= fd_d;
      ovr_q    <= ovr_d;
      busy_q   <= busy_d;
      col_q    <= col_d;
      row_q    <= row_d;
    end
  end

  assign edge_out_o   = edge_q;
  assign edge_valid_o = ev_q;
  assign frame_done_o = fd_q;
  assign overrun_o    = ovr_q;
  assign busy_o       = busy_q;

endmodule
